// File: rtl/msrv32_lu_pkg.sv
// Shared types for the load unit: FSM state encoding, load size codes and
// the size-code to byte-count helper.
package msrv32_lu_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BEAT0 = 2'd1,
      BEAT1 = 2'd2,
      RESP  = 2'd3
   } lu_state_e;

   localparam logic [1:0] SIZE_B = 2'b00;
   localparam logic [1:0] SIZE_H = 2'b01;
   localparam logic [1:0] SIZE_W = 2'b10;
   localparam logic [1:0] SIZE_D = 2'b11;

   // A double on a 32-bit datapath degrades to a word.
   function automatic logic [3:0] nbytes_of(input logic [1:0] size, input int unsigned xlen);
      logic [3:0] n;
      case (size)
         SIZE_B:  n = 4'd1;
         SIZE_H:  n = 4'd2;
         SIZE_W:  n = 4'd4;
         default: n = (xlen == 64) ? 4'd8 : 4'd4;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/msrv32_lu_extract.sv
// Combinational load alignment: shift the two-beat window down by the byte
// offset, keep nbytes bytes and sign- or zero-extend to XLEN.
module msrv32_lu_extract #(
   parameter int unsigned XLEN = 32
) (
   input  logic [2*XLEN-1:0]         beats,
   input  logic [$clog2(XLEN/8)-1:0] offset,
   input  logic [3:0]                nbytes,
   input  logic                      is_unsigned,
   output logic [XLEN-1:0]           data_c
);

   localparam int unsigned IDX_W = $clog2(XLEN);

   logic [XLEN-1:0]  low;
   logic [XLEN-1:0]  mask;
   logic [IDX_W-1:0] sidx;
   logic             ext;
   int unsigned      nbits;

   always_comb begin
      low   = XLEN'(beats >> {offset, 3'b000});
      nbits = 32'(nbytes) * 32'd8;
      mask  = '1;
      sidx  = IDX_W'(XLEN - 1);
      if (nbits < XLEN) begin
         mask = (XLEN'(1) << nbits) - XLEN'(1);
         sidx = IDX_W'(nbits - 1);
      end
      ext    = ~is_unsigned & low[sidx];
      data_c = (low & mask) | ({XLEN{ext}} & ~mask);
   end

endmodule

// File: rtl/msrv32_lu_split.sv
// Load unit with sign/zero extension and optional split of line-crossing
// accesses into two bus beats (enabled by MSRV32_LU_MISALIGN_EN).
module msrv32_lu_split
   import msrv32_lu_pkg::*;
#(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned ADDR_W = 32
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              req_valid_in,
   output logic              req_ready_out,
   input  logic [ADDR_W-1:0] addr_in,
   input  logic [1:0]        load_size_in,
   input  logic              load_unsigned_in,
   output logic              bus_req_out,
   output logic [ADDR_W-1:0] bus_addr_out,
   input  logic [XLEN-1:0]   bus_rdata_in,
   input  logic              bus_ready_in,
   input  logic              bus_err_in,
   output logic              lu_valid_out,
   output logic [XLEN-1:0]   lu_output,
   output logic              lu_err_out,
   output logic              misaligned_out
);

   localparam int unsigned BYTES = XLEN / 8;
   localparam int unsigned OFF_W = $clog2(BYTES);

   lu_state_e         state_q, state_d;
   logic [OFF_W-1:0]  off_q;
   logic [3:0]        nbytes_q;
   logic              unsigned_q;
   logic [3:0]        nbytes_in;
   logic              accept;
   logic              misalign_c;
   logic              resp_err_c;
   logic              resp_mis_c;
   logic              enter_resp;
   logic [2*XLEN-1:0] beats_c;
   logic [XLEN-1:0]   extract_c;

   assign nbytes_in = nbytes_of(load_size_in, XLEN);
   assign accept    = req_valid_in && (state_q == IDLE);

`ifdef MSRV32_LU_MISALIGN_EN
   logic [XLEN-1:0] beat0_q;
   logic            spans_c;

   assign misalign_c = 1'b0;
   assign spans_c    = (32'(off_q) + 32'(nbytes_q)) > BYTES;
   assign beats_c    = (state_q == BEAT1) ? {bus_rdata_in, beat0_q}
                                          : {{XLEN{1'b0}}, bus_rdata_in};
`else
   assign misalign_c = (addr_in[3:0] & (nbytes_in - 4'd1)) != 4'd0;
   assign beats_c    = {{XLEN{1'b0}}, bus_rdata_in};
`endif

   // Next state plus the error/misaligned flags carried into RESP.
   always_comb begin
      state_d    = state_q;
      resp_err_c = 1'b0;
      resp_mis_c = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_valid_in) begin
               if (misalign_c) begin
                  state_d    = RESP;
                  resp_err_c = 1'b1;
                  resp_mis_c = 1'b1;
               end else begin
                  state_d = BEAT0;
               end
            end
         end
         BEAT0: begin
            if (bus_ready_in) begin
               resp_err_c = bus_err_in;
`ifdef MSRV32_LU_MISALIGN_EN
               state_d = (!bus_err_in && spans_c) ? BEAT1 : RESP;
`else
               state_d = RESP;
`endif
            end
         end
`ifdef MSRV32_LU_MISALIGN_EN
         BEAT1: begin
            if (bus_ready_in) begin
               resp_err_c = bus_err_in;
               state_d    = RESP;
            end
         end
`endif
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign enter_resp = (state_d == RESP) && (state_q != RESP);

   msrv32_lu_extract #(.XLEN(XLEN)) u_extract (
      .beats       (beats_c),
      .offset      (off_q),
      .nbytes      (nbytes_q),
      .is_unsigned (unsigned_q),
      .data_c      (extract_c)
   );

   always_ff @(posedge clk_in) begin
      if (rst_in) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Request capture, beat addressing and registered result/handshake outputs.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         req_ready_out  <= 1'b1;
         bus_req_out    <= 1'b0;
         bus_addr_out   <= '0;
         lu_valid_out   <= 1'b0;
         lu_output      <= '0;
         lu_err_out     <= 1'b0;
         misaligned_out <= 1'b0;
         off_q          <= '0;
         nbytes_q       <= 4'd1;
         unsigned_q     <= 1'b0;
`ifdef MSRV32_LU_MISALIGN_EN
         beat0_q        <= '0;
`endif
      end else begin
         req_ready_out <= (state_d == IDLE);
         bus_req_out   <= (state_d == BEAT0) || (state_d == BEAT1);
         lu_valid_out  <= (state_d == RESP);
         if (accept) begin
            off_q        <= addr_in[OFF_W-1:0];
            nbytes_q     <= nbytes_in;
            unsigned_q   <= load_unsigned_in;
            bus_addr_out <= addr_in & ~ADDR_W'(BYTES - 1);
         end
`ifdef MSRV32_LU_MISALIGN_EN
         if ((state_q == BEAT0) && (state_d == BEAT1)) begin
            beat0_q      <= bus_rdata_in;
            bus_addr_out <= bus_addr_out + ADDR_W'(BYTES);
         end
`endif
         if (enter_resp) begin
            lu_err_out     <= resp_err_c;
            misaligned_out <= resp_mis_c;
            lu_output      <= resp_err_c ? '0 : extract_c;
         end
      end
   end

endmodule

// File: tb/tb_msrv32_lu_split.sv
// Directed bench for msrv32_lu_split: 32-bit vector table plus reset and
// 64-bit corner sequences; expectations follow MSRV32_LU_MISALIGN_EN.
module tb_msrv32_lu_split;
   import msrv32_lu_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // 32-bit instance signals
   logic        rst32, req_valid, req_ready, uns, bus_req, bus_ready, bus_err;
   logic        lu_valid, lu_err, lu_mis;
   logic [31:0] addr, bus_addr, bus_rdata, lu_data;
   logic [1:0]  size;

   // 64-bit instance signals
   logic        rst64, req_valid64, req_ready64, uns64, bus_req64, bus_ready64, bus_err64;
   logic        lu_valid64, lu_err64, lu_mis64;
   logic [31:0] addr64, bus_addr64;
   logic [63:0] bus_rdata64, lu_data64;
   logic [1:0]  size64;

   msrv32_lu_split #(.XLEN(32), .ADDR_W(32)) u_dut32 (
      .clk_in(clk), .rst_in(rst32), .req_valid_in(req_valid), .req_ready_out(req_ready),
      .addr_in(addr), .load_size_in(size), .load_unsigned_in(uns),
      .bus_req_out(bus_req), .bus_addr_out(bus_addr), .bus_rdata_in(bus_rdata),
      .bus_ready_in(bus_ready), .bus_err_in(bus_err), .lu_valid_out(lu_valid),
      .lu_output(lu_data), .lu_err_out(lu_err), .misaligned_out(lu_mis)
   );

   msrv32_lu_split #(.XLEN(64), .ADDR_W(32)) u_dut64 (
      .clk_in(clk), .rst_in(rst64), .req_valid_in(req_valid64), .req_ready_out(req_ready64),
      .addr_in(addr64), .load_size_in(size64), .load_unsigned_in(uns64),
      .bus_req_out(bus_req64), .bus_addr_out(bus_addr64), .bus_rdata_in(bus_rdata64),
      .bus_ready_in(bus_ready64), .bus_err_in(bus_err64), .lu_valid_out(lu_valid64),
      .lu_output(lu_data64), .lu_err_out(lu_err64), .misaligned_out(lu_mis64)
   );

   typedef struct {
      logic [31:0] addr;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] rd0, rd1;
      int          err_beat;   // 0 none, 1 first beat, 2 second beat
      int          waits;      // wait cycles before each beat completes
      logic [31:0] exp_data;
      logic        exp_err, exp_mis;
      int          exp_beats, exp_lat;
      logic [31:0] exp_a0, exp_a1;
   } vec_t;

   localparam int NV = 14;
   vec_t vecs[NV];
   int n_pass = 0;
   int n_total = 0;

   function automatic vec_t mk(input logic [31:0] a, input logic [1:0] s, input logic u,
                               input logic [31:0] r0, input logic [31:0] r1, input int eb,
                               input int w, input logic [31:0] d, input logic e, input logic m,
                               input int nb, input int lat, input logic [31:0] a0,
                               input logic [31:0] a1);
      vec_t v;
      v.addr = a; v.size = s; v.uns = u; v.rd0 = r0; v.rd1 = r1; v.err_beat = eb;
      v.waits = w; v.exp_data = d; v.exp_err = e; v.exp_mis = m; v.exp_beats = nb;
      v.exp_lat = lat; v.exp_a0 = a0; v.exp_a1 = a1;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      else n_pass++;
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int cycles, beats, seen;
      logic got;
      logic [31:0] a0, a1;
      @(negedge clk);
      addr = v.addr; size = v.size; uns = v.uns; req_valid = 1'b1;
      chk($sformatf("v%0d_ready_idle", idx), 64'(req_ready), 64'd1);
      @(posedge clk);
      got = 1'b0; cycles = 0; beats = 0; seen = 0; a0 = '0; a1 = '0;
      while (!got && cycles < 20) begin
         @(negedge clk);
         cycles++;
         req_valid = 1'b0;
         if (cycles == 1) chk($sformatf("v%0d_ready_busy", idx), 64'(req_ready), 64'd0);
         if (lu_valid) begin
            got = 1'b1; bus_ready = 1'b0; bus_err = 1'b0;
         end else if (bus_req && seen == v.waits) begin
            bus_ready = 1'b1;
            bus_rdata = (beats == 0) ? v.rd0 : v.rd1;
            bus_err   = (v.err_beat == beats + 1);
            if (beats == 0) a0 = bus_addr; else a1 = bus_addr;
            beats++; seen = 0;
         end else begin
            if (bus_req) seen++;
            bus_ready = 1'b0; bus_err = 1'b0;
         end
      end
      chk($sformatf("v%0d_valid_seen", idx), 64'(got), 64'd1);
      chk($sformatf("v%0d_latency", idx), 64'(cycles), 64'(v.exp_lat));
      chk($sformatf("v%0d_data", idx), 64'(lu_data), 64'(v.exp_data));
      chk($sformatf("v%0d_err", idx), 64'(lu_err), 64'(v.exp_err));
      chk($sformatf("v%0d_mis", idx), 64'(lu_mis), 64'(v.exp_mis));
      chk($sformatf("v%0d_beats", idx), 64'(beats), 64'(v.exp_beats));
      if (v.exp_beats >= 1) chk($sformatf("v%0d_addr0", idx), 64'(a0), 64'(v.exp_a0));
      if (v.exp_beats == 2) chk($sformatf("v%0d_addr1", idx), 64'(a1), 64'(v.exp_a1));
      @(negedge clk);
      chk($sformatf("v%0d_valid_pulse", idx), 64'(lu_valid), 64'd0);
      chk($sformatf("v%0d_data_hold", idx), 64'(lu_data), 64'(v.exp_data));
   endtask

   task automatic load64(input string name, input logic [31:0] a, input logic [1:0] s,
                         input logic u, input logic [63:0] rd, input logic [31:0] exp_a,
                         input logic [63:0] exp_d);
      @(negedge clk);
      addr64 = a; size64 = s; uns64 = u; req_valid64 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid64 = 1'b0;
      chk({name, "_breq"}, 64'(bus_req64), 64'd1);
      chk({name, "_baddr"}, 64'(bus_addr64), 64'(exp_a));
      bus_ready64 = 1'b1; bus_rdata64 = rd;
      @(negedge clk);
      bus_ready64 = 1'b0;
      chk({name, "_valid"}, 64'(lu_valid64), 64'd1);
      chk({name, "_data"}, lu_data64, exp_d);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic saw;
      rst32 = 1'b1; req_valid = 1'b0; addr = '0; size = '0; uns = 1'b0;
      bus_ready = 1'b0; bus_err = 1'b0; bus_rdata = '0;
      rst64 = 1'b1; req_valid64 = 1'b0; addr64 = '0; size64 = '0; uns64 = 1'b0;
      bus_ready64 = 1'b0; bus_err64 = 1'b0; bus_rdata64 = '0;

      vecs[0]  = mk(32'h103, SIZE_B, 0, 32'h8000_0000, 32'h0, 0, 0, 32'hFFFF_FF80, 0, 0, 1, 2, 32'h100, 32'h0);
      vecs[1]  = mk(32'h202, SIZE_H, 1, 32'hBEEF_1234, 32'h0, 0, 0, 32'h0000_BEEF, 0, 0, 1, 2, 32'h200, 32'h0);
      vecs[4]  = mk(32'h400, SIZE_W, 0, 32'h8765_4321, 32'h0, 0, 0, 32'h8765_4321, 0, 0, 1, 2, 32'h400, 32'h0);
      vecs[5]  = mk(32'h008, SIZE_D, 1, 32'hDEAD_BEEF, 32'h0, 0, 0, 32'hDEAD_BEEF, 0, 0, 1, 2, 32'h008, 32'h0);
      vecs[6]  = mk(32'h3FF, SIZE_B, 1, 32'hFE00_0000, 32'h0, 0, 0, 32'h0000_00FE, 0, 0, 1, 2, 32'h3FC, 32'h0);
      vecs[10] = mk(32'h500, SIZE_W, 0, 32'h1234_5678, 32'h0, 1, 0, 32'h0, 1, 0, 1, 2, 32'h500, 32'h0);
      vecs[12] = mk(32'h101, SIZE_B, 1, 32'h0000_AB00, 32'h0, 0, 2, 32'h0000_00AB, 0, 0, 1, 4, 32'h100, 32'h0);
`ifdef MSRV32_LU_MISALIGN_EN
      vecs[2]  = mk(32'h0FE, SIZE_W, 0, 32'hAAAA_1111, 32'h2222_5555, 0, 0, 32'h5555_AAAA, 0, 0, 2, 3, 32'h0FC, 32'h100);
      vecs[3]  = mk(32'h201, SIZE_H, 0, 32'h1280_FF34, 32'h0, 0, 0, 32'hFFFF_80FF, 0, 0, 1, 2, 32'h200, 32'h0);
      vecs[7]  = mk(32'h3FF, SIZE_H, 0, 32'h7F00_0000, 32'h0000_0081, 0, 0, 32'hFFFF_817F, 0, 0, 2, 3, 32'h3FC, 32'h400);
      vecs[8]  = mk(32'hFFFF_FFFE, SIZE_W, 1, 32'h3344_0000, 32'h0000_1122, 0, 0, 32'h1122_3344, 0, 0, 2, 3, 32'hFFFF_FFFC, 32'h0);
      vecs[9]  = mk(32'h3FF, SIZE_H, 0, 32'h7F00_0000, 32'h0000_0081, 1, 0, 32'h0, 1, 0, 1, 2, 32'h3FC, 32'h0);
      vecs[11] = mk(32'h0FE, SIZE_W, 0, 32'hAAAA_1111, 32'h2222_5555, 2, 0, 32'h0, 1, 0, 2, 3, 32'h0FC, 32'h100);
      vecs[13] = mk(32'h0FE, SIZE_W, 0, 32'hAAAA_1111, 32'h2222_5555, 0, 1, 32'h5555_AAAA, 0, 0, 2, 5, 32'h0FC, 32'h100);
`else
      vecs[2]  = mk(32'h0FE, SIZE_W, 0, 32'hAAAA_1111, 32'h2222_5555, 0, 0, 32'h0, 1, 1, 0, 1, 32'h0, 32'h0);
      vecs[3]  = mk(32'h201, SIZE_H, 0, 32'h1280_FF34, 32'h0, 0, 0, 32'h0, 1, 1, 0, 1, 32'h0, 32'h0);
      vecs[7]  = mk(32'h3FF, SIZE_H, 0, 32'h7F00_0000, 32'h0000_0081, 0, 0, 32'h0, 1, 1, 0, 1, 32'h0, 32'h0);
      vecs[8]  = mk(32'hFFFF_FFFE, SIZE_W, 1, 32'h3344_0000, 32'h0000_1122, 0, 0, 32'h0, 1, 1, 0, 1, 32'h0, 32'h0);
      vecs[9]  = mk(32'h3FF, SIZE_H, 0, 32'h7F00_0000, 32'h0000_0081, 1, 0, 32'h0, 1, 1, 0, 1, 32'h0, 32'h0);
      vecs[11] = mk(32'h0FE, SIZE_W, 0, 32'hAAAA_1111, 32'h2222_5555, 2, 0, 32'h0, 1, 1, 0, 1, 32'h0, 32'h0);
      vecs[13] = mk(32'h0FE, SIZE_W, 0, 32'hAAAA_1111, 32'h2222_5555, 0, 1, 32'h0, 1, 1, 0, 1, 32'h0, 32'h0);
`endif

      repeat (3) @(posedge clk);
      @(negedge clk);
      rst32 = 1'b0; rst64 = 1'b0;
      chk("rst_ready", 64'(req_ready), 64'd1);
      chk("rst_breq", 64'(bus_req), 64'd0);
      chk("rst_valid", 64'(lu_valid), 64'd0);
      chk("rst_data", 64'(lu_data), 64'd0);
      chk("rst_err", 64'(lu_err), 64'd0);
      chk("rst_mis", 64'(lu_mis), 64'd0);
      chk("rst64_ready", 64'(req_ready64), 64'd1);
      chk("rst64_breq", 64'(bus_req64), 64'd0);

      for (int i = 0; i < NV; i++) run_vec(vecs[i], i);

      // Reset during a stalled beat, with bus_ready raised in the reset cycle
      @(negedge clk);
      addr = 32'h400; size = SIZE_W; uns = 1'b0; req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      chk("mid_rst_breq_before", 64'(bus_req), 64'd1);
      rst32 = 1'b1; bus_ready = 1'b1; bus_rdata = 32'h1111_2222;
      @(negedge clk);
      rst32 = 1'b0; bus_ready = 1'b0;
      chk("mid_rst_ready", 64'(req_ready), 64'd1);
      chk("mid_rst_breq", 64'(bus_req), 64'd0);
      chk("mid_rst_data_clr", 64'(lu_data), 64'd0);
      saw = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (lu_valid) saw = 1'b1;
      end
      chk("mid_rst_no_valid", 64'(saw), 64'd0);

      // 64-bit: double at 0x8, reset while beat stalls
      @(negedge clk);
      addr64 = 32'h8; size64 = SIZE_D; uns64 = 1'b0; req_valid64 = 1'b1;
      chk("r64_ready_idle", 64'(req_ready64), 64'd1);
      @(posedge clk);
      @(negedge clk);
      req_valid64 = 1'b0;
      chk("r64_breq", 64'(bus_req64), 64'd1);
      chk("r64_baddr", 64'(bus_addr64), 64'h8);
      rst64 = 1'b1;
      @(negedge clk);
      rst64 = 1'b0;
      chk("r64_ready_after", 64'(req_ready64), 64'd1);
      chk("r64_breq_after", 64'(bus_req64), 64'd0);
      chk("r64_valid_after", 64'(lu_valid64), 64'd0);
      saw = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (lu_valid64) saw = 1'b1;
      end
      chk("r64_no_valid", 64'(saw), 64'd0);

      load64("d64", 32'h8, SIZE_D, 1'b0, 64'h0123_4567_89AB_CDEF, 32'h8, 64'h0123_4567_89AB_CDEF);
      load64("w64", 32'hC, SIZE_W, 1'b0, 64'h8000_0000_0000_0000, 32'h8, 64'hFFFF_FFFF_8000_0000);
      load64("h64", 32'hE, SIZE_H, 1'b1, 64'hBEEF_0000_0000_0000, 32'h8, 64'h0000_0000_0000_BEEF);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/msrv32_lu_split.md
MSRV32_LU_SPLIT -- requirements
Module: msrv32_lu_split

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning data path width in bits; legal values 32 and 64.
REQ-002 SHALL have parameter ADDR_W, default 32, meaning load address width in bits.
REQ-003 SHALL have one clock and a synchronous, active-high reset: clk_in and rst_in.
REQ-004 clk_in  input  1  clock; all state updates on its rising edge.
REQ-005 rst_in  input  1  synchronous active-high reset.
REQ-006 req_valid_in  input  1  load request present.
REQ-007 req_ready_out  output  1  block can accept a request.
REQ-008 addr_in  input  ADDR_W  byte address of the load.
REQ-009 load_size_in  input  2  size code: 00 byte, 01 half, 10 word, 11 double.
REQ-010 load_unsigned_in  input  1  1 zero-extends, 0 sign-extends.
REQ-011 bus_req_out  output  1  bus beat request.
REQ-012 bus_addr_out  output  ADDR_W  beat address, aligned to XLEN/8 bytes.
REQ-013 bus_rdata_in  input  XLEN  beat read data.
REQ-014 bus_ready_in  input  1  beat complete.
REQ-015 bus_err_in  input  1  beat error; sampled only with bus_ready_in.
REQ-016 lu_valid_out  output  1  result valid, one-cycle pulse.
REQ-017 lu_output  output  XLEN  extended load result.
REQ-018 lu_err_out  output  1  result is an error; qualified by lu_valid_out.
REQ-019 misaligned_out  output  1  error cause is misalignment; qualified by lu_valid_out.

Function
REQ-020 FSM states SHALL be IDLE, BEAT0, BEAT1 and RESP.
REQ-021 req_ready_out SHALL be 1 only in IDLE; a request is accepted when req_valid_in and req_ready_out are both 1, and addr, size and unsigned are captured.
REQ-022 bus_req_out SHALL be 1 only in BEAT0/BEAT1; bus_addr_out SHALL be the aligned-down address in BEAT0 and that address + XLEN/8 in BEAT1, with wrap-around modulo 2^ADDR_W.
REQ-023 In BEAT0/BEAT1 the block SHALL hold state until bus_ready_in=1 and SHALL capture bus_rdata_in on that cycle.
REQ-024 offset = addr mod XLEN/8; nbytes = 1, 2, 4 or 8 by size; when XLEN=32, size 11 SHALL behave as 10.
REQ-025 An access spans when offset + nbytes > XLEN/8; BEAT0 completion goes to BEAT1 if spanning, else to RESP.
REQ-026 bus_err_in=1 at any beat completion SHALL go directly to RESP with lu_err_out=1, misaligned_out=0, lu_output=0, and SHALL skip BEAT1.
REQ-027 Result = {beat1, beat0} shifted right by offset*8, truncated to nbytes, then extended to XLEN by load_unsigned; beat1 SHALL be 0 if not fetched.
REQ-028 RESP SHALL assert lu_valid_out for exactly one cycle, then go to IDLE.
REQ-029 lu_output SHALL be registered and hold its value outside RESP.
REQ-030 Latency, zero-wait bus, from the accept edge: SHALL be 2 cycles to lu_valid_out for a single beat and 3 cycles for a split access.

Reset
REQ-031 rst_in SHALL force IDLE and clear lu_output, lu_valid_out, lu_err_out and misaligned_out to 0; bus_req_out SHALL be 0 and req_ready_out SHALL be 1 in the cycle after reset.
REQ-032 Reset mid-operation SHALL abandon the access without producing lu_valid_out.
REQ-033 A bus_ready_in in the reset cycle SHALL be ignored.

Configuration
REQ-034 Macro MSRV32_LU_MISALIGN_EN defined: spanning accesses SHALL be split per REQ-025, and non-naturally-aligned accesses that do not span SHALL complete normally.
REQ-035 MSRV32_LU_MISALIGN_EN undefined: any access with addr mod nbytes != 0 SHALL issue no bus beat and go IDLE->RESP with lu_err_out=1, misaligned_out=1, lu_output=0; BEAT1 logic SHALL be absent.

Structure
REQ-036 Package msrv32_lu_pkg SHALL hold the FSM state enum, the size-code constants and the nbytes-of-size function.
REQ-037 Combinational shift, truncate and extend SHALL live in sub-module msrv32_lu_extract (XLEN-parametrised).

Verification
REQ-038 XLEN=32, byte load at 0x103, signed, rdata 0x80_00_00_00 -> bus_addr 0x100, lu_output 0xFFFFFF80 two cycles after accept.
REQ-039 XLEN=32, half at 0x202, unsigned, rdata 0xBEEF_1234 -> lu_output 0x0000BEEF, single beat.
REQ-040 XLEN=32, macro on, word at 0x0FE, beats 0xAAAA_xxxx then 0xxxxx_5555 -> beats at 0x0FC and 0x100, lu_output 0x5555AAAA, 3-cycle latency with zero wait.
REQ-041 Macro off, same word at 0x0FE -> no bus_req_out, lu_err_out=1 and misaligned_out=1 in the cycle after accept.
REQ-042 bus_err_in=1 on BEAT0 of a split load -> no BEAT1, lu_err_out=1, lu_output=0.
REQ-043 XLEN=64, double at 0x8, with rst_in pulsed during BEAT0 while bus_ready_in is held low -> no lu_valid_out, req_ready_out=1 next cycle, bus_req_out=0.
